rep3_decoder_pl: RTL and testbench
==================================

# rep3_decoder_pl

Pipelined receive-side checker for the 18-bit-data / 21-bit-codeword format, in which codeword bits [20:18] repeat data bits [2:0]. It accepts codewords over a valid/ready stream and strips them back to 18-bit data. It computes a 3-bit repetition syndrome per word, flags and counts detected errors, and optionally drops corrupted words. The block sits between the channel/receive buffer and the data consumer, mirroring the encoder on the transmit side.

## Interface
Parameters:
- W_CNT, 16, width of the word and error counters
- DROP_ON_ERR, 0, when 1 a word with nonzero syndrome is discarded instead of forwarded

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  codeword on c is valid
- in_ready  out  1  block can accept a codeword this cycle
- c  in  21  received codeword
- out_valid  out  1  b/err/syndrome valid
- out_ready  in  1  consumer accepts output this cycle
- b  out  18  decoded data
- err  out  1  syndrome nonzero for word on b
- syndrome  out  3  per-bit mismatch for word on b
- clr_cnt  in  1  synchronous counter clear
- word_count  out  W_CNT  codewords accepted, saturating
- err_count  out  W_CNT  codewords with err, saturating

## Operation
- Decode: syndrome[i] = c[i] ^ c[18+i], i=0..2; err = |syndrome; b = c[17:0]. No correction: two copies give detection only.
- Two-stage pipeline. S1 registers c, syndrome, and valid. S2 is the output register (b, err, syndrome, out_valid).
- s2_load = s1_valid && (!out_valid || out_ready); in_ready = !s1_valid || s2_load (combinational from out_ready).
- Input handshake: in_valid && in_ready at an edge loads S1. An output transfer is out_valid && out_ready at an edge.
- DROP_ON_ERR=1: when S1 holds an erroring word, S1 empties without loading S2. This drop needs no downstream readiness; for this word, s2_load is replaced by "S1 empties unconditionally".
- Counters update at the S1 load edge. word_count increments on every accepted codeword; err_count increments when that codeword's syndrome is nonzero. Both saturate at 2^W_CNT-1 and hold.
- clr_cnt: both counters go to 0 at the edge. clr_cnt wins over a simultaneous increment, and that word is not counted.
- Ordering strictly preserved; no word is duplicated or lost except by DROP_ON_ERR.
- Data held stable on b/err/syndrome while out_valid && !out_ready.

## Timing
- Reset (synchronous, active-high): S1/S2 valid=0, out_valid=0, b=0, err=0, syndrome=0, word_count=0, err_count=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight words are discarded and not emitted; counters are cleared. Reset overrides all handshakes and clr_cnt.
- Latency: a word accepted at edge k has out_valid=1 after edge k+1, given no backpressure.
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure: with out_ready=0, two words are buffered (S1+S2), then in_ready=0. When out_ready rises, in_ready=1 in the same cycle (S2 drains, S1 advances).
- Simultaneous output transfer and S1 advance at the same edge is legal and required for full throughput.
- Counter values are visible the cycle after the accept edge, before the word reaches the output.

## Test plan
- Clean word: c=21'h16A5A5 accepted at edge k -> out_valid after k+1, b=18'h2A5A5, err=0, syndrome=3'b000, word_count=1, err_count=0.
- Single error: c=21'h1EA5A5 (c[19] flipped) -> b=18'h2A5A5, syndrome=3'b010, err=1, err_count=1. Also c=21'h16A5A4 (c[0] flipped) -> syndrome=3'b001.
- Backpressure: out_ready=0, present 3 clean words back-to-back -> 2 accepted, then in_ready=0 with b held stable. Raise out_ready -> all 3 delivered in order, one per cycle, with no gap after resumption.
- DROP_ON_ERR=1: stream clean, error, clean -> only 2 outputs appear; word_count=3, err_count=1. in_ready is never stalled by the dropped word.
- Saturation/clear with W_CNT=4: 17 accepted words -> word_count=15 holds. clr_cnt asserted on the same edge as an accept -> word_count=0 after that edge.
- Reset mid-stream: 2 words in flight with out_ready=0, assert reset one cycle -> out_valid=0, counters=0, in_ready=1 afterward. The dropped words never appear.

Source files
------------

// File: rtl/rep3_decoder_pl.sv
// rep3_decoder_pl: two-stage valid/ready checker for 21-bit codewords whose
// top three bits repeat data bits [2:0]; strips to 18-bit data, flags errors.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready/c   codeword input stream
//   out_valid/out_ready   output stream carrying b, err, syndrome
//   b                     decoded data (codeword bits [17:0])
//   err, syndrome         mismatch flag and per-bit mismatch for b
//   clr_cnt               synchronous clear of both counters
//   word_count/err_count  saturating accepted-word and error-word counters
module rep3_decoder_pl #(
    parameter int W_CNT       = 16,
    parameter bit DROP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      b,
    output logic             err,
    output logic [2:0]       syndrome,
    input  logic             clr_cnt,
    output logic [W_CNT-1:0] word_count,
    output logic [W_CNT-1:0] err_count
);

    localparam logic [W_CNT-1:0] CNT_MAX = '1;

    logic        s1_valid;
    logic [17:0] s1_b;
    logic [2:0]  s1_syn;

    logic [2:0]  in_syn;
    logic        s1_drop;
    logic        s2_load;
    logic        s1_empty;
    logic        accept;

    assign in_syn   = c[2:0] ^ c[20:18];

    // An erroring word in drop mode leaves S1 regardless of the consumer.
    assign s1_drop  = DROP_ON_ERR && s1_valid && (|s1_syn);
    assign s2_load  = s1_valid && !s1_drop && (!out_valid || out_ready);
    assign s1_empty = s2_load || s1_drop;
    assign in_ready = !s1_valid || s1_empty;
    assign accept   = in_valid && in_ready;

    // S1: decoded word plus syndrome; a new accept takes priority over emptying.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_b     <= '0;
            s1_syn   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_b     <= c[17:0];
            s1_syn   <= in_syn;
        end else if (s1_empty) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: output register; data only changes on a load, so it holds under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            b         <= '0;
            err       <= 1'b0;
            syndrome  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            b         <= s1_b;
            err       <= |s1_syn;
            syndrome  <= s1_syn;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Counters track accepts, not deliveries; clear beats a same-edge increment.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            word_count <= '0;
            err_count  <= '0;
        end else if (accept) begin
            if (word_count != CNT_MAX) begin
                word_count <= word_count + 1'b1;
            end
            if ((|in_syn) && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rep3_decoder_pl.sv
// tb_rep3_decoder_pl: scoreboard bench for rep3_decoder_pl.
// Instance a: W_CNT=4, forwarding errors; instance d: default width, drop mode.
module tb_rep3_decoder_pl;

    typedef struct packed {
        logic [20:0] c;
        logic [17:0] b;
        logic [2:0]  s;
    } vec_t;

    logic clk;
    logic reset;

    logic        a_iv, a_in_ready, a_out_valid, a_ordy, a_err, a_clr;
    logic [20:0] a_c;
    logic [17:0] a_b;
    logic [2:0]  a_syn;
    logic [3:0]  a_wc, a_ec;

    logic        d_iv, d_in_ready, d_out_valid, d_ordy, d_err, d_clr;
    logic [20:0] d_c;
    logic [17:0] d_b;
    logic [2:0]  d_syn;
    logic [15:0] d_wc, d_ec;

    int checks;
    int errors;
    int d_nout;
    int ewa, eea, ewd, eed;

    logic [21:0] qa[$];
    logic [21:0] qd[$];

    vec_t tbl[9] = '{
        '{21'h16A5A5, 18'h2A5A5, 3'b000},
        '{21'h1EA5A5, 18'h2A5A5, 3'b010},
        '{21'h16A5A4, 18'h2A5A4, 3'b001},
        '{21'h000000, 18'h00000, 3'b000},
        '{21'h1C0000, 18'h00000, 3'b111},
        '{21'h03FFFF, 18'h3FFFF, 3'b111},
        '{21'h1FFFFF, 18'h3FFFF, 3'b000},
        '{21'h0C0003, 18'h00003, 3'b000},
        '{21'h123456, 18'h23456, 3'b010}
    };

    rep3_decoder_pl #(.W_CNT(4), .DROP_ON_ERR(1'b0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(a_iv), .in_ready(a_in_ready), .c(a_c),
        .out_valid(a_out_valid), .out_ready(a_ordy),
        .b(a_b), .err(a_err), .syndrome(a_syn),
        .clr_cnt(a_clr), .word_count(a_wc), .err_count(a_ec)
    );

    rep3_decoder_pl #(.W_CNT(16), .DROP_ON_ERR(1'b1)) dut_d (
        .clk(clk), .reset(reset),
        .in_valid(d_iv), .in_ready(d_in_ready), .c(d_c),
        .out_valid(d_out_valid), .out_ready(d_ordy),
        .b(d_b), .err(d_err), .syndrome(d_syn),
        .clr_cnt(d_clr), .word_count(d_wc), .err_count(d_ec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: pop and compare on every output transfer.
    always @(negedge clk) begin : mon
        logic [21:0] e;
        if (!reset && a_out_valid && a_ordy) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got b=%0h want no output", a_b);
            end else begin
                e = qa.pop_front();
                chk("a_out", {10'd0, a_b, a_err, a_syn}, {10'd0, e});
            end
        end
        if (!reset && d_out_valid && d_ordy) begin
            d_nout++;
            if (qd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected: got b=%0h want no output", d_b);
            end else begin
                e = qd.pop_front();
                chk("d_out", {10'd0, d_b, d_err, d_syn}, {10'd0, e});
            end
        end
    end

    task automatic send_a(input vec_t v, input bit want_out, output int waits);
        a_iv = 1'b1;
        a_c  = v.c;
        waits = 0;
        @(negedge clk);
        while (!a_in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!a_in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: in_ready=0 want 1");
        end else begin
            if (want_out) qa.push_back({v.b, |v.s, v.s});
            if (a_clr) begin
                ewa = 0;
                eea = 0;
            end else begin
                if (ewa != 15) ewa++;
                if (v.s != 3'b000 && eea != 15) eea++;
            end
        end
        @(posedge clk);
        #1;
        a_iv = 1'b0;
    endtask

    task automatic send_d(input vec_t v, input bit want_out, output int waits);
        d_iv = 1'b1;
        d_c  = v.c;
        waits = 0;
        @(negedge clk);
        while (!d_in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!d_in_ready) begin
            checks++;
            errors++;
            $display("FAIL d_accept_timeout: in_ready=0 want 1");
        end else begin
            if (want_out) qd.push_back({v.b, |v.s, v.s});
            ewd++;
            if (v.s != 3'b000) eed++;
        end
        @(posedge clk);
        #1;
        d_iv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded want finish");
        $fatal(1);
    end

    initial begin
        int w;
        int tot;
        checks = 0; errors = 0; d_nout = 0;
        ewa = 0; eea = 0; ewd = 0; eed = 0;
        reset = 1'b1;
        a_iv = 0; a_c = '0; a_ordy = 0; a_clr = 0;
        d_iv = 0; d_c = '0; d_ordy = 0; d_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_b", {a_b, a_err, a_syn}, 0);
        chk("rst_wc", a_wc, 0);
        chk("rst_ec", a_ec, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_d_in_ready", d_in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, visible after k+1; counter first.
        a_ordy = 1'b1;
        send_a(tbl[0], 1'b1, w);
        @(negedge clk);
        chk("lat_not_yet", a_out_valid, 0);
        chk("lat_wc", a_wc, 1);
        chk("lat_ec", a_ec, 0);
        @(negedge clk);
        chk("lat_out_valid", a_out_valid, 1);
        idle(2);

        // Single-bit errors in the copy and in the data.
        send_a(tbl[1], 1'b1, w);
        send_a(tbl[2], 1'b1, w);
        idle(3);
        chk("err_wc", a_wc, 3);
        chk("err_ec", a_ec, 2);

        // Full throughput, back-to-back.
        tot = 0;
        for (int i = 3; i < 9; i++) begin
            send_a(tbl[i], 1'b1, w);
            tot += w;
        end
        chk("thru_stalls", tot, 0);
        idle(3);
        chk("thru_wc", a_wc, 9);
        chk("thru_ec", a_ec, 5);

        // Backpressure: two buffered, third stalls, b held.
        a_ordy = 1'b0;
        send_a(tbl[0], 1'b1, w);
        send_a(tbl[6], 1'b1, w);
        a_iv = 1'b1;
        a_c  = tbl[7].c;
        @(negedge clk);
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_b", a_b, 18'h2A5A5);
        repeat (2) begin
            @(negedge clk);
            chk("bp_b_hold", a_b, 18'h2A5A5);
        end
        @(posedge clk);
        #1;
        a_ordy = 1'b1;
        send_a(tbl[7], 1'b1, w);
        chk("bp_resume_ready", w, 0);
        @(negedge clk);
        chk("bp_run2", a_out_valid, 1);
        @(negedge clk);
        chk("bp_run3", a_out_valid, 1);
        idle(3);
        chk("bp_wc", a_wc, 12);

        // Saturation at 15 with W_CNT=4 (17 accepts total).
        for (int i = 0; i < 5; i++) begin
            send_a(tbl[i], 1'b1, w);
        end
        idle(3);
        chk("sat_wc", a_wc, 15);
        chk("sat_ec", a_ec, 8);
        chk("sat_wc_model", a_wc, ewa);

        // Clear on the same edge as an accept.
        a_clr = 1'b1;
        send_a(tbl[1], 1'b1, w);
        a_clr = 1'b0;
        chk("clr_wc", a_wc, 0);
        chk("clr_ec", a_ec, 0);
        send_a(tbl[1], 1'b1, w);
        chk("clr_after_wc", a_wc, 1);
        chk("clr_after_ec", a_ec, 1);
        idle(3);

        // Reset mid-stream discards two in-flight words.
        a_ordy = 1'b0;
        send_a(tbl[3], 1'b0, w);
        send_a(tbl[6], 1'b0, w);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ewa = 0;
        eea = 0;
        @(negedge clk);
        chk("mrst_out_valid", a_out_valid, 0);
        chk("mrst_wc", a_wc, 0);
        chk("mrst_ec", a_ec, 0);
        chk("mrst_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        a_ordy = 1'b1;
        idle(4);
        send_a(tbl[7], 1'b1, w);
        idle(3);
        chk("mrst_after_wc", a_wc, 1);

        // Drop mode: clean, error, clean with consumer ready.
        d_ordy = 1'b1;
        tot = 0;
        send_d(tbl[0], 1'b1, w); tot += w;
        send_d(tbl[1], 1'b0, w); tot += w;
        send_d(tbl[7], 1'b1, w); tot += w;
        chk("drop_stalls", tot, 0);
        idle(4);
        chk("drop_nout", d_nout, 2);
        chk("drop_wc", d_wc, 3);
        chk("drop_ec", d_ec, 1);

        // Drop needs no downstream readiness.
        d_ordy = 1'b0;
        tot = 0;
        send_d(tbl[3], 1'b1, w); tot += w;
        send_d(tbl[4], 1'b0, w); tot += w;
        send_d(tbl[6], 1'b1, w); tot += w;
        chk("drop_bp_stalls", tot, 0);
        d_ordy = 1'b1;
        idle(5);
        chk("drop_bp_nout", d_nout, 4);
        chk("drop_bp_wc", d_wc, 6);
        chk("drop_bp_ec", d_ec, 2);
        chk("drop_model_wc", d_wc, ewd);
        chk("drop_model_ec", d_ec, eed);

        chk("a_queue_empty", qa.size(), 0);
        chk("d_queue_empty", qd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
